logic_4b_checker: RTL

LOGIC_4B_CHECKER -- requirements
Module: logic_4b_checker

---
 rtl/logic_4b_checker.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/logic_4b_checker.sv
`default_nettype none
// ============================================================================
// Module      : logic_4b_checker
// Description : Run-based checker for a 4-bit two-input logic gate. Each valid
//               vector (x, y, op, dut_out) sampled while RUN is compared against
//               the reference gate result in a two-stage pipeline. The block
//               counts checked vectors and mismatches (saturating) and records
//               the first failing vector of the run.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   start          in   begin a run from IDLE or DONE (clears all results)
//   stop           in   end the run (RUN only); wins over start in RUN
//   valid          in   x/y/op/dut_out carry a vector this cycle
//   op[1:0]        in   00 AND, 01 NAND, 10 OR, 11 XOR
//   x, y[3:0]      in   gate operands
//   dut_out[3:0]   in   gate result to be checked
//   busy           out  high in RUN and DRAIN
//   done           out  high in DONE
//   pass           out  done, no mismatches, at least one vector checked
//   check_cnt      out  vectors checked (saturating)
//   err_cnt        out  mismatching vectors (saturating)
//   first_err_*    out  valid flag and x/y/dut_out of first mismatch
//
// Revision    : 1.0  initial release
// ============================================================================
module logic_4b_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             valid,
    input  logic [1:0]       op,
    input  logic [3:0]       x,
    input  logic [3:0]       y,
    input  logic [3:0]       dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_err_vld,
    output logic [3:0]       first_err_x,
    output logic [3:0]       first_err_y,
    output logic [3:0]       first_err_out
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t r_state;
    logic   r_busy;
    logic   r_done;

    // Stage-1 registers
    logic       r_s1_vld;
    logic [3:0] r_s1_x;
    logic [3:0] r_s1_y;
    logic [3:0] r_s1_out;
    logic [3:0] r_s1_exp;

    // Result registers
    logic [CNT_W-1:0] r_check_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_ferr_vld;
    logic [3:0]       r_ferr_x;
    logic [3:0]       r_ferr_y;
    logic [3:0]       r_ferr_out;

    logic       w_start_ok;
    logic       w_sample;
    logic       w_mismatch;
    logic [3:0] w_exp;

    // A run may only be (re)started from IDLE or DONE. In RUN, stop has
    // priority, so start is simply never looked at there.
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_sample   = valid && (r_state == ST_RUN);
    assign w_mismatch = r_s1_vld && (r_s1_out != r_s1_exp);

    // Reference gate result
    always_comb begin
        w_exp = 4'b0000;
        case (op)
            2'b00:   w_exp = x & y;
            2'b01:   w_exp = ~(x & y);
            2'b10:   w_exp = x | y;
            2'b11:   w_exp = x ^ y;
            default: w_exp = 4'b0000;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered busy/done
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Single cycle that lets the vector sampled on the stop
                    // edge retire before results are declared final.
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                ST_DONE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture the vector and its expected result
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_x   <= 4'b0000;
            r_s1_y   <= 4'b0000;
            r_s1_out <= 4'b0000;
            r_s1_exp <= 4'b0000;
        end else if (w_start_ok) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_sample;
            if (w_sample) begin
                r_s1_x   <= x;
                r_s1_y   <= y;
                r_s1_out <= dut_out;
                r_s1_exp <= w_exp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: compare, count, record the first failure
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_check_cnt <= '0;
            r_err_cnt   <= '0;
            r_ferr_vld  <= 1'b0;
            r_ferr_x    <= 4'b0000;
            r_ferr_y    <= 4'b0000;
            r_ferr_out  <= 4'b0000;
        end else if (w_start_ok) begin
            r_check_cnt <= '0;
            r_err_cnt   <= '0;
            r_ferr_vld  <= 1'b0;
            r_ferr_x    <= 4'b0000;
            r_ferr_y    <= 4'b0000;
            r_ferr_out  <= 4'b0000;
        end else if (r_s1_vld) begin
            if (r_check_cnt != c_cnt_max) begin
                r_check_cnt <= r_check_cnt + c_cnt_one;
            end
            if (w_mismatch) begin
                if (r_err_cnt != c_cnt_max) begin
                    r_err_cnt <= r_err_cnt + c_cnt_one;
                end
                if (!r_ferr_vld) begin
                    r_ferr_vld <= 1'b1;
                    r_ferr_x   <= r_s1_x;
                    r_ferr_y   <= r_s1_y;
                    r_ferr_out <= r_s1_out;
                end
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_done && (r_err_cnt == '0) && (r_check_cnt != '0);
    assign check_cnt     = r_check_cnt;
    assign err_cnt       = r_err_cnt;
    assign first_err_vld = r_ferr_vld;
    assign first_err_x   = r_ferr_x;
    assign first_err_y   = r_ferr_y;
    assign first_err_out = r_ferr_out;

endmodule
`default_nettype wire
